// File: rtl/ps_frame_pkg.sv
// Shared types and default K-character codes for the 8b10b frame sequencer.
package ps_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    PAYLOAD,
    CRC,
    EOF
  } state_t;

  localparam logic [7:0] K_IDLE_DFLT = 8'h3C;  // K28.1
  localparam logic [7:0] K_SOF_DFLT  = 8'hBC;  // K28.5
  localparam logic [7:0] K_EOF_DFLT  = 8'hFD;  // K29.7

endpackage

// File: rtl/crc8_update.sv
// One-byte CRC-8 step, MSB-first, no reflection, fully unrolled.
module crc8_update #(
  parameter logic [7:0] POLYNOMIAL = 8'h07
) (
  input  logic [7:0] crc_i,
  input  logic [7:0] byte_i,
  output logic [7:0] crc_o
);

  logic [7:0] c;

  always_comb begin
    c = crc_i ^ byte_i;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/ps_frame_sequencer.sv
// Frames payload bytes as SOF, payload, CRC-8, EOF for the 8b10b encoder;
// idle K-chars fill every slot without data.
module ps_frame_sequencer
  import ps_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 8,
  parameter logic [7:0]  POLYNOMIAL  = 8'h07,
  parameter logic [7:0]  CRC_INIT    = 8'h00,
  parameter logic [7:0]  K_IDLE      = K_IDLE_DFLT,
  parameter logic [7:0]  K_SOF       = K_SOF_DFLT,
  parameter logic [7:0]  K_EOF       = K_EOF_DFLT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] count_q, count_d;
  logic [7:0] enc_data_q, enc_data_d;
  logic       enc_k_q, enc_k_d;
  logic       frame_done_q, frame_done_d;
  logic       underrun_q, underrun_d;
  logic [7:0] crc_next;

  crc8_update #(.POLYNOMIAL(POLYNOMIAL)) u_crc (
    .crc_i  (crc_q),
    .byte_i (s_data),
    .crc_o  (crc_next)
  );

  // Symbol registers load what the current state emits, so a byte accepted
  // at an edge is on enc_data right after that same edge.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    count_d      = count_q;
    enc_data_d   = K_IDLE;
    enc_k_d      = 1'b1;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = SOF;
          crc_d   = CRC_INIT;
          count_d = '0;
        end
      end
      SOF: begin
        enc_data_d = K_SOF;
        state_d    = PAYLOAD;
      end
      PAYLOAD: begin
        if (s_valid) begin
          enc_data_d = s_data;
          enc_k_d    = 1'b0;
          crc_d      = crc_next;
          count_d    = count_q + 8'd1;
          if (count_q == LAST_IDX) begin
            state_d = CRC;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      CRC: begin
        enc_data_d = crc_q;
        enc_k_d    = 1'b0;
        state_d    = EOF;
      end
      EOF: begin
        enc_data_d   = K_EOF;
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      crc_q        <= CRC_INIT;
      count_q      <= '0;
      enc_data_q   <= K_IDLE;
      enc_k_q      <= 1'b1;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      count_q      <= count_d;
      enc_data_q   <= enc_data_d;
      enc_k_q      <= enc_k_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign s_ready    = (state_q == PAYLOAD);
  assign busy       = (state_q != IDLE);
  assign enc_data   = enc_data_q;
  assign enc_k      = enc_k_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ps_frame_sequencer.sv
// Directed bench: one sequencer with a 9-byte payload, one with a 1-byte payload.
module tb_ps_frame_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] s_data9, s_data1;
  logic       s_valid9, s_valid1;
  logic       s_ready9, s_ready1;
  logic [7:0] enc_data9, enc_data1;
  logic       enc_k9, enc_k1;
  logic       busy9, busy1;
  logic       frame_done9, frame_done1;
  logic       underrun9, underrun1;

  int checks = 0;
  int errors = 0;

  ps_frame_sequencer #(.PAYLOAD_LEN(9)) dut9 (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data9),
    .s_valid    (s_valid9),
    .s_ready    (s_ready9),
    .enc_data   (enc_data9),
    .enc_k      (enc_k9),
    .busy       (busy9),
    .frame_done (frame_done9),
    .underrun   (underrun9)
  );

  ps_frame_sequencer #(.PAYLOAD_LEN(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data1),
    .s_valid    (s_valid1),
    .s_ready    (s_ready1),
    .enc_data   (enc_data1),
    .enc_k      (enc_k1),
    .busy       (busy1),
    .frame_done (frame_done1),
    .underrun   (underrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [7:0] e_data;
    logic       e_k;
    logic       e_fd;
    logic       e_ur;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  vec_t t9[14];
  vec_t t1[11];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [7:0] ed,
                              input logic ek, input logic fd, input logic ur,
                              input logic bs, input logic rd);
    vec_t r;
    r.v = v; r.d = d; r.e_data = ed; r.e_k = ek;
    r.e_fd = fd; r.e_ur = ur; r.e_busy = bs; r.e_rdy = rd;
    return r;
  endfunction

  function automatic logic [12:0] obs(input bit sel1);
    if (sel1) return {enc_data1, enc_k1, frame_done1, underrun1, busy1, s_ready1};
    return {enc_data9, enc_k9, frame_done9, underrun9, busy9, s_ready9};
  endfunction

  task automatic chk(input string name, input bit sel1, input logic [12:0] exp);
    logic [12:0] got;
    got = obs(sel1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got{data,k,fd,ur,busy,rdy}=%h/%b%b%b%b%b exp=%h/%b%b%b%b%b",
               name, got[12:5], got[4], got[3], got[2], got[1], got[0],
               exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string name, input bit sel1, input vec_t v);
    if (sel1) begin
      s_valid1 = v.v; s_data1 = v.d; s_valid9 = 1'b0;
    end else begin
      s_valid9 = v.v; s_data9 = v.d; s_valid1 = 1'b0;
    end
    step();
    chk(name, sel1, {v.e_data, v.e_k, v.e_fd, v.e_ur, v.e_busy, v.e_rdy});
  endtask

  // Full "123456789" frame on dut9 from IDLE, optionally stalling after byte stall_after.
  task automatic send_frame9(input string tag, input int stall_after, input int stall_n);
    s_valid9 = 1'b1; s_data9 = 8'h31;
    step(); chk({tag, "_idle"}, 0, {8'h3C, 5'b10010});
    step(); chk({tag, "_sof"},  0, {8'hBC, 5'b10011});
    for (int i = 0; i < 9; i++) begin
      s_valid9 = 1'b1; s_data9 = 8'h31 + 8'(i);
      step(); chk({tag, "_byte"}, 0, {8'h31 + 8'(i), 4'b0001, (i < 8)});
      if (i + 1 == stall_after) begin
        for (int s = 0; s < stall_n; s++) begin
          s_valid9 = 1'b0;
          step(); chk({tag, "_stall"}, 0, {8'h3C, 5'b10111});
        end
      end
    end
    s_valid9 = 1'b0;
    step(); chk({tag, "_crc"},  0, {8'hF4, 5'b00010});
    step(); chk({tag, "_eof"},  0, {8'hFD, 5'b11000});
    step(); chk({tag, "_gap"},  0, {8'h3C, 5'b10000});
  endtask

  initial begin
    t9[0] = mk(1, 8'h31, 8'h3C, 1, 0, 0, 1, 0);
    t9[1] = mk(1, 8'h31, 8'hBC, 1, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++)
      t9[2+i] = mk(1, 8'h31 + 8'(i), 8'h31 + 8'(i), 0, 0, 0, 1, (i < 8));
    t9[11] = mk(0, 8'h00, 8'hF4, 0, 0, 0, 1, 0);
    t9[12] = mk(0, 8'h00, 8'hFD, 1, 1, 0, 0, 0);
    t9[13] = mk(0, 8'h00, 8'h3C, 1, 0, 0, 0, 0);

    // Back-to-back single-byte frames with s_valid held: one 3C between FD and BC.
    t1[0]  = mk(1, 8'h01, 8'h3C, 1, 0, 0, 1, 0);
    t1[1]  = mk(1, 8'h01, 8'hBC, 1, 0, 0, 1, 1);
    t1[2]  = mk(1, 8'h01, 8'h01, 0, 0, 0, 1, 0);
    t1[3]  = mk(1, 8'h00, 8'h07, 0, 0, 0, 1, 0);
    t1[4]  = mk(1, 8'h00, 8'hFD, 1, 1, 0, 0, 0);
    t1[5]  = mk(1, 8'h00, 8'h3C, 1, 0, 0, 1, 0);
    t1[6]  = mk(1, 8'h00, 8'hBC, 1, 0, 0, 1, 1);
    t1[7]  = mk(1, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    t1[8]  = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    t1[9]  = mk(0, 8'h00, 8'hFD, 1, 1, 0, 0, 0);
    t1[10] = mk(0, 8'h00, 8'h3C, 1, 0, 0, 0, 0);

    reset = 1'b1;
    s_valid9 = 1'b0; s_data9 = '0;
    s_valid1 = 1'b0; s_data1 = '0;
    #1 reset = 1'b0;
    #2;
    chk("reset9", 0, {8'h3C, 5'b10000});
    chk("reset1", 1, {8'h3C, 5'b10000});
    step(); step();
    reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(); chk("idle_fill", 0, {8'h3C, 5'b10000});
    end

    for (int i = 0; i < 14; i++) run_vec("t9_vec", 0, t9[i]);
    for (int i = 0; i < 11; i++) run_vec("t1_vec", 1, t1[i]);

    send_frame9("stall", 4, 2);

    // Abandon a frame mid-payload with an asynchronous reset.
    s_valid9 = 1'b1; s_data9 = 8'h31;
    step(); step();
    step(); s_data9 = 8'h32;
    step(); chk("pre_rst", 0, {8'h32, 5'b00011});
    #2 reset = 1'b0;
    #1 chk("rst_async", 0, {8'h3C, 5'b10000});
    for (int i = 0; i < 3; i++) begin
      step(); chk("rst_hold", 0, {8'h3C, 5'b10000});
    end
    reset = 1'b1;
    send_frame9("post_rst", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
